debounce_sync: RTL and testbench



---
 rtl/debounce_sync.sv | 110 +++++++++++
 tb/tb_debounce_sync.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
// Synchronises a raw asynchronous input and releases a level change only after it has been stable for STABLE_CYCLES samples.
// Optional saturating rejected-transition counter (glitch_cnt) is enabled by defining DEBOUNCE_GLITCH_CNT_EN.
module debounce_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sig_in,
  output logic       sig_out,
  output logic       busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  localparam int              CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic                   sig_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // cnt_q holds the number of consecutive new-level samples seen so far in a PEND state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= STABLE_LO;
      cnt_q     <= '0;
      sig_out_q <= 1'b0;
    end else begin
      case (state_q)
        STABLE_LO: begin
          if (s) begin
            state_q <= PEND_HI;
            cnt_q   <= CNT_ONE;
          end
        end
        PEND_HI: begin
          if (!s) begin
            state_q <= STABLE_LO;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= STABLE_HI;
            sig_out_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!s) begin
            state_q <= PEND_LO;
            cnt_q   <= CNT_ONE;
          end
        end
        PEND_LO: begin
          if (s) begin
            state_q <= STABLE_HI;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= STABLE_LO;
            sig_out_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: state_q <= STABLE_LO;
      endcase
    end
  end

  assign sig_out = sig_out_q;
  assign busy    = (state_q == PEND_HI) || (state_q == PEND_LO);

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic       reject;
  logic [7:0] glitch_q;

  assign reject = ((state_q == PEND_HI) && !s) || ((state_q == PEND_LO) && s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_q <= 8'd0;
    end else if (reject && (glitch_q != 8'hFF)) begin
      glitch_q <= glitch_q + 8'd1;
    end
  end

  assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync: a run-length reference model predicts each cycle's outputs, a negedge monitor compares.
// glitch_cnt is checked only when DEBOUNCE_GLITCH_CNT_EN is defined.
module tb_debounce_sync;

  localparam int SYNC = 2;
  localparam int SC   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sig_in = 1'b0;
  logic       sig_out;
  logic       busy;
  logic [7:0] glitch_cnt;

  debounce_sync #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(SC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .sig_out    (sig_out),
    .busy       (busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt (glitch_cnt)
`endif
  );

`ifndef DEBOUNCE_GLITCH_CNT_EN
  assign glitch_cnt = 8'd0;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic       o;
    logic       b;
    logic [7:0] g;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   rises = 0;
  logic prev_out = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: s seen at an edge is sig_in from SYNC edges earlier; a level
  // is accepted once SC consecutive samples differ from the current output.
  logic m_delay[$];
  logic m_out;
  int   m_run;
  int   m_glitch;

  task automatic model_reset();
    m_delay.delete();
    for (int i = 0; i < SYNC; i++) m_delay.push_back(1'b0);
    m_out    = 1'b0;
    m_run    = 0;
    m_glitch = 0;
  endtask

  initial model_reset();

  always @(posedge clk) begin
    exp_t e;
    logic x;
    if (!rst_n) begin
      model_reset();
    end else begin
      x = m_delay.pop_front();
      m_delay.push_back(sig_in);
      if (x != m_out) begin
        m_run++;
        if (m_run == SC) begin
          m_out = x;
          m_run = 0;
        end
      end else begin
        if (m_run > 0 && m_glitch < 255) m_glitch++;
        m_run = 0;
      end
    end
    e.o = m_out;
    e.b = (m_run > 0);
    e.g = 8'(m_glitch);
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 8'd1, 8'd0);
    end else begin
      e = exp_q.pop_front();
      check("sb_sig_out", {7'd0, sig_out}, {7'd0, e.o});
      check("sb_busy", {7'd0, busy}, {7'd0, e.b});
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("sb_glitch_cnt", glitch_cnt, e.g);
`endif
    end
    if (sig_out && !prev_out) rises++;
    prev_out = sig_out;
  end

  task automatic hold(input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      #3 sig_in = v;
    end
  endtask

  initial begin
    int r0;
    logic [7:0] g0;

    // reset, idle
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_sig_out", {7'd0, sig_out}, 8'd0);
    check("idle_busy", {7'd0, busy}, 8'd0);
    check("idle_glitch", glitch_cnt, 8'd0);

    // rising qualification latency
    r0 = rises;
    hold(1'b1, 1);
    repeat (3) @(negedge clk);
    check("rise_busy_k2", {7'd0, busy}, 8'd1);
    repeat (2) @(negedge clk);
    check("rise_out_k4", {7'd0, sig_out}, 8'd0);
    check("rise_busy_k4", {7'd0, busy}, 8'd1);
    @(negedge clk);
    check("rise_out_k5", {7'd0, sig_out}, 8'd1);
    check("rise_busy_k5", {7'd0, busy}, 8'd0);
    repeat (8) @(negedge clk);
    check("single_pe", 8'(rises - r0), 8'd1);

    // falling qualification
    g0 = glitch_cnt;
    hold(1'b0, 1);
    repeat (5) @(negedge clk);
    check("fall_out_k4", {7'd0, sig_out}, 8'd1);
    @(negedge clk);
    check("fall_out_k5", {7'd0, sig_out}, 8'd0);
    check("fall_glitch_same", glitch_cnt, g0);

    // two-cycle glitch
    repeat (5) @(negedge clk);
    hold(1'b1, 2);
    hold(1'b0, 10);
    check("glitch_out", {7'd0, sig_out}, 8'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("glitch_cnt_1", glitch_cnt, 8'd1);
`endif

    // saturation
    for (int i = 0; i < 300; i++) begin
      hold(1'b1, 2);
      hold(1'b0, 10);
    end
    check("sat_out", {7'd0, sig_out}, 8'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("sat_glitch", glitch_cnt, 8'd255);
`endif

    // randomized levels and hold times
    for (int i = 0; i < 400; i++) begin
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 8));
    end
    hold(1'b0, 12);

    // async reset in PEND_HI, then requalify with input still high
    hold(1'b1, 1);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {7'd0, busy}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_sig_out", {7'd0, sig_out}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_glitch", glitch_cnt, 8'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rel_out_k4", {7'd0, sig_out}, 8'd0);
    @(negedge clk);
    check("rel_out_k5", {7'd0, sig_out}, 8'd1);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
